uart_rx_fifo: RTL and testbench

- UART receiver: the receive end of the serial link that the SoC's `tx` drives toward UART_TXD, mirroring the SoC's transmit direction.
- Oversamples an asynchronous 8N1 `rx` line, recovers bytes by majority vote, and buffers them in a small FIFO.
- Presents buffered bytes on a valid/ready interface.
- Used by board tops and loopback benches to capture console output from `dut` (e.g. the "R"/"T" status bytes) without the host.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_byte_fifo.sv | 54 +++++
 rtl/uart_rx_fifo.sv | 120 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver states, frame constants and tick-divider helper
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;

  localparam int DATA_BITS = 8;

  // Clocks per oversample tick, rounded to nearest
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    return (clk_hz + baud * ovs / 2) / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: circular byte buffer with push/pop, occupancy count and full flag
module uart_byte_fifo #(
  parameter int DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  // Depth is a power of two, so the count MSB alone marks full
  assign full  = cnt_q[AW];
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  // A push into a full buffer is accepted only when the head leaves in the same cycle
  always_comb begin
    pop_ok  = pop && (cnt_q != '0);
    push_ok = push && (!full || pop_ok);
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_q] = din;
  end

  // Storage and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1 UART receiver with majority vote feeding a byte FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
  localparam int TW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVS);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_LO  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVS / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVS - 1);

  logic [1:0]           sync_q, sync_d;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [SW-1:0]        s_q, s_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [1:0]           smp_q, smp_d;
  logic                 fe_q, fe_d, ov_q, ov_d;
  logic                 rx_s, tick, dec, last, maj, push, pop, full;
  logic [$clog2(FIFO_DEPTH):0] count;

  assign rx_s        = sync_q[1];
  assign tick        = (tcnt_q == TW'(DIV - 1));
  assign dec         = tick && (s_q == S_HI);
  assign last        = tick && (s_q == S_END);
  assign maj         = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign rx_valid    = (count != '0);
  assign pop         = rx_valid && rx_ready;
  assign framing_err = fe_q;
  assign overrun     = ov_q;

  // All state registers, including the input synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      tcnt_q  <= '0;
      s_q     <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      smp_q   <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      smp_q   <= smp_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  // Next state: frame sequencing driven by majority decisions at mid-bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   state_d = (dec && maj) ? IDLE : last ? DATA : START;
      DATA:    if (last && bit_q == BW'(DATA_BITS - 1)) state_d = STOP;
      STOP:    if (dec) state_d = maj ? IDLE : BREAK;
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: tick and sample counters held in IDLE so ticks align to the start edge
  always_comb begin
    sync_d = {sync_q[0], rx};
    tcnt_d = (state_q == IDLE || tick) ? '0 : tcnt_q + 1'b1;
    s_d    = (state_q == IDLE) ? '0 : !tick ? s_q : (s_q == S_END) ? '0 : s_q + 1'b1;
    bit_d  = (state_q != DATA) ? '0 : last ? bit_q + 1'b1 : bit_q;
    sh_d   = (state_q == DATA && dec) ? {maj, sh_q[DATA_BITS-1:1]} : sh_q;
    smp_d  = smp_q;
    if (tick && s_q == S_LO) smp_d[0] = rx_s;
    if (tick && s_q == S_MID) smp_d[1] = rx_s;
  end

  // Outputs: byte completion, error strobes and busy
  always_comb begin
    push = (state_q == STOP) && dec && maj;
    fe_d = (state_q == STOP) && dec && !maj;
    ov_d = push && full && !pop;
    busy = (state_q != IDLE);
  end

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (sh_q),
    .dout  (rx_data),
    .count (count),
    .full  (full)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized frame stimulus checked against a queue model of the receiver
module tb_uart_rx_fifo;

  localparam int BIT = 16;

  logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, framing_err, overrun, busy;

  int          n_tests = 0, n_fail = 0;
  int          fe_cnt = 0, ov_cnt = 0, pop_cnt = 0, vld_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] e;
  logic [7:0]  t2 [5] = '{8'h01, 8'h80, 8'hFF, 8'h52, 8'h54};

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_HZ(1600000), .BAUD(100000), .OVS(16), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    clocks(BIT);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  // Consumer side: every accepted byte must be the oldest byte the model holds
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) vld_cnt++;
      if (framing_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        pop_cnt++;
        e = 32'h100;
        if (exp_q.size() != 0) e = {24'h0, exp_q.pop_front()};
        chk("rx_data", {24'h0, rx_data}, e);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int f0, o0, p0, v0, lat, L, exp_ov;
    bit seen;
    logic [7:0] b;
    clocks(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fe", framing_err, 0);
    chk("rst_ov", overrun, 0);
    reset = 1'b0;
    clocks(5);
    // single byte, latency and single-cycle valid with a ready consumer
    rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    v0 = vld_cnt; f0 = fe_cnt; o0 = ov_cnt; lat = 0; seen = 1'b0;
    fork
      send_frame(8'h55, 1'b1);
      while (!seen && lat < 300) begin
        @(posedge clk); #1;
        lat++;
        seen = rx_valid;
      end
    join
    clocks(10);
    chk("t1_seen", seen, 1);
    chk("t1_latency_window", (lat >= 152 && lat <= 158), 1);
    chk("t1_valid_cycles", vld_cnt - v0, 1);
    chk("t1_fe", fe_cnt - f0, 0);
    chk("t1_ov", ov_cnt - o0, 0);
    chk("t1_model_empty", exp_q.size(), 0);
    L = lat;
    // fill with consumer stalled, fifth byte overruns
    rx_ready = 1'b0; o0 = ov_cnt; f0 = fe_cnt; exp_ov = 0;
    foreach (t2[i]) begin
      if (exp_q.size() < 4) exp_q.push_back(t2[i]);
      else exp_ov++;
      send_frame(t2[i], 1'b1);
    end
    clocks(3);
    chk("t2_overrun", ov_cnt - o0, exp_ov);
    chk("t2_valid", rx_valid, 1);
    chk("t2_head", rx_data, exp_q[0]);
    p0 = pop_cnt;
    rx_ready = 1'b1;
    clocks(10);
    chk("t2_drained", pop_cnt - p0, 4);
    chk("t2_model_empty", exp_q.size(), 0);
    chk("t2_valid_low", rx_valid, 0);
    chk("t2_fe", fe_cnt - f0, 0);
    // short low glitch is a false start
    f0 = fe_cnt; o0 = ov_cnt; p0 = pop_cnt;
    rx = 1'b0;
    clocks(4);
    rx = 1'b1;
    chk("t3_busy_rise", busy, 1);
    clocks(12);
    chk("t3_busy_fall", busy, 0);
    chk("t3_pops", pop_cnt - p0, 0);
    chk("t3_fe", fe_cnt - f0, 0);
    chk("t3_ov", ov_cnt - o0, 0);
    // bad stop bit followed by a held-low line, then recovery
    f0 = fe_cnt; p0 = pop_cnt;
    send_frame(8'h41, 1'b0);
    clocks(64);
    rx = 1'b1;
    clocks(20);
    chk("t4_fe_once", fe_cnt - f0, 1);
    chk("t4_nothing_pushed", pop_cnt - p0, 0);
    chk("t4_idle", busy, 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    clocks(10);
    chk("t4_recover", pop_cnt - p0, 1);
    chk("t4_model_empty", exp_q.size(), 0);
    // full FIFO with a pop exactly on the push cycle
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    clocks(3);
    chk("t5_full_valid", rx_valid, 1);
    o0 = ov_cnt; p0 = pop_cnt;
    b = 8'($urandom);
    exp_q.push_back(b);
    fork
      send_frame(b, 1'b1);
      begin
        clocks(L - 1);
        rx_ready = 1'b1;
        clocks(1);
        rx_ready = 1'b0;
      end
    join
    clocks(3);
    chk("t5_no_overrun", ov_cnt - o0, 0);
    chk("t5_one_pop", pop_cnt - p0, 1);
    p0 = pop_cnt;
    rx_ready = 1'b1;
    clocks(10);
    chk("t5_drain_count", pop_cnt - p0, 4);
    chk("t5_model_empty", exp_q.size(), 0);
    // asynchronous reset mid-frame discards the partial byte and buffered data
    rx_ready = 1'b0; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    clocks(3);
    chk("t6_prefill", rx_valid, 1);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        clocks(BIT * 5 + BIT / 2);
        chk("t6_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", rx_valid, 0);
        chk("t6_data", rx_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_fe", framing_err, 0);
        chk("t6_ov", overrun, 0);
      end
    join
    exp_q.delete();
    clocks(2);
    reset = 1'b0;
    clocks(5);
    rx_ready = 1'b1; p0 = pop_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    clocks(10);
    chk("t6_after_rx", pop_cnt - p0, 1);
    chk("t6_model_empty", exp_q.size(), 0);
    chk("t6_no_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);
    // random bytes, random gaps and a randomly stalling consumer
    p0 = pop_cnt; f0 = fe_cnt; o0 = ov_cnt;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      clocks(1 + $urandom_range(0, 20));
      exp_q.push_back(b);
      fork
        send_frame(b, 1'b1);
        for (int k = 0; k < BIT * 10; k++) begin
          rx_ready = 1'($urandom_range(0, 1));
          clocks(1);
        end
      join
    end
    rx_ready = 1'b1;
    clocks(10);
    chk("rand_pops", pop_cnt - p0, 12);
    chk("rand_model_empty", exp_q.size(), 0);
    chk("rand_fe", fe_cnt - f0, 0);
    chk("rand_ov", ov_cnt - o0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
